// File: rtl/mux_edge_pkg.sv
// ---------------------------------------------------------------------------
// mux_edge_pkg
//   Shared definitions for the mux edge timer: measurement FSM states,
//   default widths and the legal limit of the deglitch filter length.
// ---------------------------------------------------------------------------
package mux_edge_pkg;

    // Default width of the period counter and of the reported period.
    localparam int CNT_W_DEF    = 16;
    // Default number of stable synchronised samples before the level moves.
    localparam int FILT_LEN_DEF = 3;
    // Largest supported filter length; sets the filter counter width.
    localparam int FILT_LEN_MAX = 15;
    localparam int FILT_CNT_W   = $clog2(FILT_LEN_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,  // disabled, counter held at zero
        ARM     = 2'd1,  // waiting for the rise that opens an interval
        MEASURE = 2'd2   // counting cycles until the closing rise
    } state_e;

endpackage

// File: rtl/mux_edge_timer_sync_deglitch.sv
// ---------------------------------------------------------------------------
// sync_deglitch
//   Two-flop synchroniser followed by a run-length filter. The filtered
//   level only moves after FILT_LEN consecutive synchronised samples that
//   disagree with it; shorter pulses are swallowed.
//
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   din_i   in   raw asynchronous input
//   clr_i   in   clears the filter run count without touching the level
//   level_o out  filtered, synchronised level
//   rise_o  out  one-cycle strobe in the cycle after level goes 0 -> 1
// ---------------------------------------------------------------------------
module sync_deglitch
    import mux_edge_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF  // legal range 1..FILT_LEN_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    input  logic clr_i,
    output logic level_o,
    output logic rise_o
);

    localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILT_LEN - 1);

    logic                  s1_q, s2_q;
    logic                  level_q, level_d;
    logic                  level_prev_q;
    logic [FILT_CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (!clr_i && (s2_q != level_q)) begin
            // The FILT_LEN-th disagreeing sample flips the level.
            if (cnt_q == CNT_LAST) begin
                level_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so all flops sample
    // their inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            s1_q         <= din_i;
            s2_q         <= s1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~level_prev_q;

endmodule

// File: rtl/mux_edge_timer.sv
// ---------------------------------------------------------------------------
// mux_edge_timer
//   Measures the number of clk cycles between consecutive filtered rising
//   edges of the muxed signal and offers each result through a single-entry
//   valid/ready buffer. An interval that spans a mux select change, or that
//   does not fit in the counter, is discarded.
//
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   din          in   muxed signal, asynchronous to clk
//   sel          in   mux select; a change aborts the running interval
//   enable       in   measurement enable
//   period       out  measured interval in clk cycles
//   period_valid out  period holds an unconsumed value
//   period_ready in   consumer accepts period
//   level        out  filtered, synchronised din
//   overflow     out  one-cycle pulse: interval exceeded the counter range
//   missed       out  sticky: a capture was dropped with the buffer full
// ---------------------------------------------------------------------------
module mux_edge_timer
    import mux_edge_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic [1:0]       sel,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             level,
    output logic             overflow,
    output logic             missed
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             missed_q, missed_d;
    logic [1:0]       sel_q;
    logic             sel_chg;
    logic             rise;
    logic             capture;
    logic             xfer;

    // A select change only matters while a measurement is armed or running.
    assign sel_chg = (sel_q != sel) && (state_q != IDLE);

    sync_deglitch #(
        .FILT_LEN (FILT_LEN)
    ) u_sync_deglitch (
        .clk     (clk),
        .rst_n   (rst_n),
        .din_i   (din),
        .clr_i   (sel_chg),
        .level_o (level),
        .rise_o  (rise)
    );

    // Measurement FSM and interval counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        ovf_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) state_d = ARM;
            end
            ARM: begin
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                // The counter equals the distance since the opening rise,
                // so on the closing rise it is the interval itself.
                if (rise) begin
                    capture = 1'b1;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == CNT_MAX) begin
                    ovf_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ARM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        // The interval straddles two channels: throw it away and re-arm.
        if (sel_chg) begin
            state_d = ARM;
            cnt_d   = '0;
            capture = 1'b0;
            ovf_d   = 1'b0;
        end
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            capture = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    // Single-entry output buffer.
    assign xfer = valid_q && period_ready;

    always_comb begin
        period_d = period_q;
        valid_d  = valid_q;
        missed_d = missed_q;
        if (xfer) begin
            valid_d  = 1'b0;
            missed_d = 1'b0;
        end
        if (capture) begin
            // A slot freed by this cycle's transfer can take the new value.
            if (!valid_q || period_ready) begin
                period_d = cnt_q;
                valid_d  = 1'b1;
            end else begin
                missed_d = 1'b1;
            end
        end
        if (!enable) valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            missed_q <= 1'b0;
            sel_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            missed_q <= missed_d;
            sel_q    <= sel;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign overflow     = ovf_q;
    assign missed       = missed_q;

endmodule

// File: tb/tb_mux_edge_timer.sv
// ---------------------------------------------------------------------------
// tb_mux_edge_timer
//   Scoreboarded bench for mux_edge_timer (CNT_W=8, FILT_LEN=3). Expected
//   periods are queued when the closing din rise is driven and compared when
//   the DUT hands a period over (valid && ready).
// ---------------------------------------------------------------------------
module tb_mux_edge_timer;

    localparam int CNT_W    = 8;
    localparam int FILT_LEN = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             din = 1'b0;
    logic [1:0]       sel = 2'b00;
    logic             enable = 1'b0;
    logic             period_ready = 1'b0;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             level;
    logic             overflow;
    logic             missed;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int din_cyc  = 0;

    int   exp_q[$];       // expected periods, in hand-over order
    int   lvl_rise_q[$];  // cycle labels of observed level rises
    int   vld_rise_q[$];  // cycle labels of observed period_valid rises
    int   ovf_q[$];       // cycle labels of observed overflow pulses
    logic lvl_prev = 1'b0;
    logic vld_prev = 1'b0;

    mux_edge_timer #(
        .CNT_W    (CNT_W),
        .FILT_LEN (FILT_LEN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .sel          (sel),
        .enable       (enable),
        .period       (period),
        .period_valid (period_valid),
        .period_ready (period_ready),
        .level        (level),
        .overflow     (overflow),
        .missed       (missed)
    );

    always #5 clk = ~clk;

    // cyc labels the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (period_valid && period_ready) begin
                if (exp_q.size() > 0) check("period", longint'(period), longint'(exp_q.pop_front()));
                else check("spurious_xfer", longint'(period_valid), 0);
            end
            if (level && !lvl_prev)        lvl_rise_q.push_back(cyc);
            if (period_valid && !vld_prev) vld_rise_q.push_back(cyc);
            if (overflow)                  ovf_q.push_back(cyc);
        end
        lvl_prev <= level;
        vld_prev <= period_valid;
    end

    // Advance n rising edges; inputs change 1 time unit after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One din period; exp > 0 queues the interval this rise should close.
    task automatic pulse_rise(input int hi, input int lo, input int exp);
        din = 1'b1;
        if (exp > 0) exp_q.push_back(exp);
        tick(hi);
        din = 1'b0;
        tick(lo);
    endtask

    task automatic clear_mon();
        lvl_rise_q.delete();
        vld_rise_q.delete();
        ovf_q.delete();
    endtask

    task automatic restart(input logic rdy);
        enable = 1'b0;
        tick(2);
        period_ready = rdy;
        enable = 1'b1;
        tick(2);
        clear_mon();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        tick(3);
        check("rst_period", longint'(period), 0);
        check("rst_valid", longint'(period_valid), 0);
        check("rst_level", longint'(level), 0);
        check("rst_overflow", longint'(overflow), 0);
        check("rst_missed", longint'(missed), 0);
        rst_n = 1'b1;
        tick(2);

        // Square wave 10 high / 10 low, consumer always ready.
        restart(1'b1);
        din_cyc = cyc;
        pulse_rise(10, 10, 0);
        for (int i = 0; i < 3; i++) pulse_rise(10, 10, 20);
        tick(10);
        check("sq_level_rises", lvl_rise_q.size(), 4);
        check("sq_valid_rises", vld_rise_q.size(), 3);
        if (lvl_rise_q.size() >= 2 && vld_rise_q.size() >= 1) begin
            // din is first sampled on the edge after it is driven.
            check("lat_din_to_level", lvl_rise_q[0] - din_cyc - 1, FILT_LEN + 1);
            check("lat_level_to_valid", vld_rise_q[0] - lvl_rise_q[1], 1);
            check("sq_rise_spacing", lvl_rise_q[1] - lvl_rise_q[0], 20);
        end
        check("sq_drain", exp_q.size(), 0);

        // Glitches: 2-cycle pulse is filtered, 3-cycle pulse gets through.
        restart(1'b1);
        din = 1'b1;
        tick(2);
        din = 1'b0;
        tick(12);
        check("glitch2_level", lvl_rise_q.size(), 0);
        check("glitch2_valid", vld_rise_q.size(), 0);
        din = 1'b1;
        tick(3);
        din = 1'b0;
        tick(12);
        check("pulse3_level", lvl_rise_q.size(), 1);
        check("pulse3_level_back", longint'(level), 0);
        check("pulse3_valid", vld_rise_q.size(), 0);

        // Back-pressure: second capture dropped while the first is held.
        restart(1'b0);
        pulse_rise(10, 10, 0);
        pulse_rise(10, 10, 20);
        din = 1'b1;
        tick(10);
        check("hold_valid", longint'(period_valid), 1);
        check("hold_period", longint'(period), 20);
        check("hold_missed", longint'(missed), 1);
        check("hold_valid_rises", vld_rise_q.size(), 1);
        din = 1'b0;
        period_ready = 1'b1;
        tick(1);
        check("xfer_missed_clr", longint'(missed), 0);
        check("xfer_valid_clr", longint'(period_valid), 0);
        tick(9);
        pulse_rise(10, 10, 20);
        check("rdy_valid_rises", vld_rise_q.size(), 2);
        check("rdy_drain", exp_q.size(), 0);

        // Overflow: one rise then din held low.
        restart(1'b1);
        pulse_rise(10, 290, 0);
        check("ovf_count", ovf_q.size(), 1);
        if (ovf_q.size() == 1 && lvl_rise_q.size() == 1)
            // The counter holds 1 on the edge after the level rise.
            check("ovf_delay", ovf_q[0] - lvl_rise_q[0] - 1, 255);
        check("ovf_no_valid", vld_rise_q.size(), 0);
        // Back in ARM: the next rise only opens an interval.
        pulse_rise(10, 10, 0);
        pulse_rise(10, 10, 20);
        check("ovf_rearm_valid", vld_rise_q.size(), 1);
        check("ovf_rearm_drain", exp_q.size(), 0);

        // Select change shortly before a rise discards that interval.
        restart(1'b1);
        pulse_rise(10, 10, 0);
        pulse_rise(10, 9, 20);
        sel = 2'b01;
        tick(1);
        pulse_rise(10, 10, 0);
        pulse_rise(10, 10, 20);
        check("sel_valid_rises", vld_rise_q.size(), 2);
        check("sel_drain", exp_q.size(), 0);

        // Asynchronous reset in MEASURE with a held result.
        restart(1'b0);
        pulse_rise(10, 10, 0);
        din = 1'b1;
        tick(8);
        check("pre_rst_valid", longint'(period_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_period", longint'(period), 0);
        check("arst_valid", longint'(period_valid), 0);
        check("arst_level", longint'(level), 0);
        check("arst_overflow", longint'(overflow), 0);
        check("arst_missed", longint'(missed), 0);
        din = 1'b0;
        tick(2);
        rst_n = 1'b1;
        period_ready = 1'b1;
        tick(2);
        clear_mon();
        pulse_rise(10, 10, 0);
        pulse_rise(10, 10, 20);
        check("post_rst_valid_rises", vld_rise_q.size(), 1);
        check("post_rst_drain", exp_q.size(), 0);
        check("post_rst_no_ovf", ovf_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
